// File: rtl/dpram_access_ctrl.sv
// Dual-client valid/ready initiator for an async dual-port RAM.
// Optional COLLISION_CNT_EN adds a saturating write-collision counter.
module dpram_access_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_data,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_data,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_din_a,
  input  logic [DATA_W-1:0] ram_dout_a,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_din_b,
  input  logic [DATA_W-1:0] ram_dout_b
`ifdef COLLISION_CNT_EN
  ,
  output logic [15:0]       coll_cnt
`endif
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t prio_q;
  prio_t prio_d;

  logic conflict;
  logic a_acc;
  logic b_acc;
  logic rd_pend_a;
  logic rd_pend_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;

  assign conflict = a_req_valid && b_req_valid &&
                    a_req_we && b_req_we &&
                    (a_req_addr == b_req_addr);

  assign a_req_ready = !conflict || (prio_q == PRIO_A);
  assign b_req_ready = !conflict || (prio_q == PRIO_B);

  assign a_acc = a_req_valid && a_req_ready;
  assign b_acc = b_req_valid && b_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= PRIO_A;
    else     prio_q <= prio_d;
  end

  // Rotate the grant after every collision so neither client starves.
  always_comb begin
    prio_d = prio_q;
    if (conflict) begin
      case (prio_q)
        PRIO_A:  prio_d = PRIO_B;
        PRIO_B:  prio_d = PRIO_A;
        default: prio_d = PRIO_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we_a   <= 1'b0;
      ram_addr_a <= '0;
      ram_din_a  <= '0;
      rd_pend_a  <= 1'b0;
    end else begin
      ram_we_a  <= a_acc && a_req_we;
      rd_pend_a <= a_acc && !a_req_we;
      if (a_acc) begin
        ram_addr_a <= a_req_addr;
        ram_din_a  <= a_req_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we_b   <= 1'b0;
      ram_addr_b <= '0;
      ram_din_b  <= '0;
      rd_pend_b  <= 1'b0;
    end else begin
      ram_we_b  <= b_acc && b_req_we;
      rd_pend_b <= b_acc && !b_req_we;
      if (b_acc) begin
        ram_addr_b <= b_req_addr;
        ram_din_b  <= b_req_wdata;
      end
    end
  end

  // Write-first: a read racing the other port's write returns the new data.
  always_comb begin
    rd_data_a = ram_dout_a;
    rd_data_b = ram_dout_b;
    if (ram_we_b && (ram_addr_b == ram_addr_a))
      rd_data_a = ram_din_b;
    if (ram_we_a && (ram_addr_a == ram_addr_b))
      rd_data_b = ram_din_a;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rsp_valid <= 1'b0;
      a_rsp_data  <= '0;
      b_rsp_valid <= 1'b0;
      b_rsp_data  <= '0;
    end else begin
      a_rsp_valid <= rd_pend_a;
      b_rsp_valid <= rd_pend_b;
      if (rd_pend_a) a_rsp_data <= rd_data_a;
      if (rd_pend_b) b_rsp_data <= rd_data_b;
    end
  end

`ifdef COLLISION_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      coll_cnt <= '0;
    else if (conflict && (coll_cnt != 16'hFFFF))
      coll_cnt <= coll_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dpram_access_ctrl.sv
// Directed self-checking bench for dpram_access_ctrl.
// Models the async RAM; COLLISION_CNT_EN enables counter checks.
module tb_dpram_access_ctrl;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req_valid = 1'b0;
  logic          a_req_ready;
  logic          a_req_we = 1'b0;
  logic [AW-1:0] a_req_addr = '0;
  logic [DW-1:0] a_req_wdata = '0;
  logic          a_rsp_valid;
  logic [DW-1:0] a_rsp_data;
  logic          b_req_valid = 1'b0;
  logic          b_req_ready;
  logic          b_req_we = 1'b0;
  logic [AW-1:0] b_req_addr = '0;
  logic [DW-1:0] b_req_wdata = '0;
  logic          b_rsp_valid;
  logic [DW-1:0] b_rsp_data;
  logic          ram_we_a;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_din_a;
  logic [DW-1:0] ram_dout_a;
  logic          ram_we_b;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_din_b;
  logic [DW-1:0] ram_dout_b;
`ifdef COLLISION_CNT_EN
  logic [15:0]   coll_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [2**AW];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
  end

  assign ram_dout_a = mem[ram_addr_a];
  assign ram_dout_b = mem[ram_addr_b];

  dpram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_req_valid (a_req_valid),
    .a_req_ready (a_req_ready),
    .a_req_we    (a_req_we),
    .a_req_addr  (a_req_addr),
    .a_req_wdata (a_req_wdata),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_data  (a_rsp_data),
    .b_req_valid (b_req_valid),
    .b_req_ready (b_req_ready),
    .b_req_we    (b_req_we),
    .b_req_addr  (b_req_addr),
    .b_req_wdata (b_req_wdata),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_data  (b_rsp_data),
    .ram_we_a    (ram_we_a),
    .ram_addr_a  (ram_addr_a),
    .ram_din_a   (ram_din_a),
    .ram_dout_a  (ram_dout_a),
    .ram_we_b    (ram_we_b),
    .ram_addr_b  (ram_addr_b),
    .ram_din_b   (ram_din_b),
    .ram_dout_b  (ram_dout_b)
`ifdef COLLISION_CNT_EN
    ,
    .coll_cnt    (coll_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;

    // reset state
    @(negedge clk);
    chk("rst_ram_we_a", {31'd0, ram_we_a}, 32'd0);
    chk("rst_ram_addr_b", {29'd0, ram_addr_b}, 32'd0);
    chk("rst_rsp_valid", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
    chk("rst_rsp_data", {a_rsp_data, b_rsp_data}, 32'd0);
    chk("rst_readies", {30'd0, a_req_ready, b_req_ready}, 32'd3);
    rst = 1'b0;

    // 1: reset while a read is in flight
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 3'd1;
    @(negedge clk);
    chk("t1_stage1_addr", {29'd0, ram_addr_a}, 32'd1);
    a_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t1_rst_addr", {29'd0, ram_addr_a}, 32'd0);
    chk("t1_rst_valid", {31'd0, a_rsp_valid}, 32'd0);
    @(negedge clk);
    chk("t1_no_rsp0", {31'd0, a_rsp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_no_rsp1", {31'd0, a_rsp_valid}, 32'd0);
    chk("t1_data0", {16'd0, a_rsp_data}, 32'd0);

    // 2: write then read back on client A
    a_req_valid = 1'b1; a_req_we = 1'b1;
    a_req_addr = 3'd3; a_req_wdata = 16'hBEEF;
    #1;
    chk("t2_ready_a", {31'd0, a_req_ready}, 32'd1);
    @(negedge clk);
    chk("t2_pins", {ram_we_a, 12'd0, ram_addr_a, ram_din_a},
        {1'b1, 12'd0, 3'd3, 16'hBEEF});
    a_req_we = 1'b0;
    @(negedge clk);
    chk("t2_we_pulse", {31'd0, ram_we_a}, 32'd0);
    chk("t2_early", {31'd0, a_rsp_valid}, 32'd0);
    a_req_valid = 1'b0;
    @(negedge clk);
    chk("t2_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
    chk("t2_rsp_data", {16'd0, a_rsp_data}, 32'h0000BEEF);
    @(negedge clk);
    chk("t2_pulse_end", {31'd0, a_rsp_valid}, 32'd0);
    chk("t2_data_hold", {16'd0, a_rsp_data}, 32'h0000BEEF);

    // 3: same-address write collision, rotating priority
    a_req_valid = 1'b1; a_req_we = 1'b1;
    a_req_addr = 3'd5; a_req_wdata = 16'h1111;
    b_req_valid = 1'b1; b_req_we = 1'b1;
    b_req_addr = 3'd5; b_req_wdata = 16'h2222;
    #1;
    chk("t3_grant_a", {30'd0, a_req_ready, b_req_ready}, 32'd2);
    @(negedge clk);
    chk("t3_a_write", {ram_we_a, ram_we_b, 11'd0, ram_addr_a, ram_din_a},
        {1'b1, 1'b0, 11'd0, 3'd5, 16'h1111});
    a_req_valid = 1'b0;
    #1;
    chk("t3_b_ready", {31'd0, b_req_ready}, 32'd1);
    @(negedge clk);
    chk("t3_b_write", {ram_we_a, ram_we_b, 11'd0, ram_addr_b, ram_din_b},
        {1'b0, 1'b1, 11'd0, 3'd5, 16'h2222});
    b_req_valid = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 3'd5;
    @(negedge clk);
    a_req_valid = 1'b0;
    @(negedge clk);
    chk("t3_mem5", {a_rsp_valid, 15'd0, a_rsp_data}, {1'b1, 15'd0, 16'h2222});
    a_req_valid = 1'b1; a_req_we = 1'b1;
    a_req_addr = 3'd6; a_req_wdata = 16'h3333;
    b_req_valid = 1'b1; b_req_we = 1'b1;
    b_req_addr = 3'd6; b_req_wdata = 16'h4444;
    #1;
    chk("t3_grant_b", {30'd0, a_req_ready, b_req_ready}, 32'd1);
    @(negedge clk);
    chk("t3_b_first", {30'd0, ram_we_a, ram_we_b}, 32'd1);
    a_req_valid = 1'b0; b_req_valid = 1'b0;

    // 4: write-first across clients
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1;
    a_req_addr = 3'd2; a_req_wdata = 16'h00AA;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 3'd2;
    #1;
    chk("t4_readies", {30'd0, a_req_ready, b_req_ready}, 32'd3);
    @(negedge clk);
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    @(negedge clk);
    chk("t4_wr_first", {b_rsp_valid, 15'd0, b_rsp_data},
        {1'b1, 15'd0, 16'h00AA});

    // 5: full-throughput write stream then read stream
    for (int i = 0; i < 8; i++) begin
      a_req_valid = 1'b1; a_req_we = 1'b1;
      a_req_addr = AW'(i); a_req_wdata = 16'hA000 + 16'(i);
      b_req_valid = 1'b1; b_req_we = 1'b1;
      b_req_addr = AW'(i ^ 4); b_req_wdata = 16'hB000 + 16'(i);
      #1;
      chk($sformatf("t5_wr_ready%0d", i),
          {30'd0, a_req_ready, b_req_ready}, 32'd3);
      @(negedge clk);
      chk($sformatf("t5_wr_pins%0d", i), {30'd0, ram_we_a, ram_we_b}, 32'd3);
    end
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        int k;
        k = i - 2;
        exp_a = (k < 4) ? 16'hB000 + 16'(k + 4) : 16'hA000 + 16'(k);
        exp_b = ((k ^ 4) < 4) ? 16'hB000 + 16'(k) : 16'hA000 + 16'(k ^ 4);
        chk($sformatf("t5_rsp_a%0d", k), {a_rsp_valid, 15'd0, a_rsp_data},
            {1'b1, 15'd0, exp_a});
        chk($sformatf("t5_rsp_b%0d", k), {b_rsp_valid, 15'd0, b_rsp_data},
            {1'b1, 15'd0, exp_b});
      end
      if (i < 8) begin
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = AW'(i);
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = AW'(i ^ 4);
        #1;
        chk($sformatf("t5_rd_ready%0d", i),
            {30'd0, a_req_ready, b_req_ready}, 32'd3);
      end else begin
        a_req_valid = 1'b0; b_req_valid = 1'b0;
      end
      @(negedge clk);
    end

`ifdef COLLISION_CNT_EN
    // 6: collision counter and saturation
    chk("t6_cnt2", {16'd0, coll_cnt}, 32'd2);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 3'd7;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 3'd7;
    @(negedge clk);
    chk("t6_cnt3", {16'd0, coll_cnt}, 32'd3);
    for (int i = 0; i < 65540; i++) @(negedge clk);
    chk("t6_sat", {16'd0, coll_cnt}, 32'h0000FFFF);
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    @(negedge clk);
    chk("t6_sat_hold", {16'd0, coll_cnt}, 32'h0000FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
